// File: rtl/serial_nibble_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_nibble_adder_pkg
//  Description : Shared types and constants for the serial nibble adder:
//                FSM state encoding, nibble width and default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_nibble_adder_pkg;

    // Width of one serial slice; the datapath processes one of these per cycle.
    localparam int c_NIBBLE_W      = 4;

    // Operand width used when the instantiating code does not override it.
    localparam int c_DEFAULT_WIDTH = 16;

    // Controller states: waiting for operands, rippling nibbles, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of nibble slices (and CALC cycles) for a given operand width.
    function automatic int nib_count(input int width);
        return width / c_NIBBLE_W;
    endfunction

endpackage : serial_nibble_adder_pkg
`default_nettype wire

// File: rtl/serial_nibble_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_nibble_adder_if
//  Description : Operand/result handshake bundle of the serial nibble adder.
//                master = operand producer / result consumer side,
//                slave  = the adder itself.
//                Optional macro SERIAL_NIBBLE_ADDER_SUB_EN adds the 'sub' line.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_nibble_adder_if
    import serial_nibble_adder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
    logic             sub;
`endif

`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface : serial_nibble_adder_if
`default_nettype wire

// File: rtl/serial_nibble_adder_nibble_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_adder
//  Description : Combinational 4-bit adder slice, {co, s} = x + y + ci.
//                A single instance is time-shared across all nibbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_adder
    import serial_nibble_adder_pkg::*;
(
    input  wire logic [c_NIBBLE_W-1:0] x,
    input  wire logic [c_NIBBLE_W-1:0] y,
    input  wire logic                  ci,
    output logic      [c_NIBBLE_W-1:0] s,
    output logic                       co
);

    logic [c_NIBBLE_W:0] w_total;

    // Zero-extend both operands so the carry lands in the top bit.
    always_comb begin
        w_total = {1'b0, x} + {1'b0, y} + {{c_NIBBLE_W{1'b0}}, ci};
        s       = w_total[c_NIBBLE_W-1:0];
        co      = w_total[c_NIBBLE_W];
    end

endmodule : nibble_adder
`default_nettype wire

// File: rtl/serial_nibble_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_nibble_adder
//  Description : Bit-serial-by-nibble adder. Operands are latched on accept,
//                one nibble is added per cycle through a shared nibble_adder,
//                and the result is held until the consumer takes it.
//                Optional macro SERIAL_NIBBLE_ADDER_SUB_EN enables a + ~b + 1
//                when the latched 'sub' input is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_nibble_adder
    import serial_nibble_adder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
)(
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_nibble_adder_if.slave bus
);

    localparam int c_NIB   = nib_count(WIDTH);
    localparam int c_IDX_W = $clog2(c_NIB);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NIB - 1);
    localparam logic [c_IDX_W-1:0] c_ONE  = c_IDX_W'(1);

    // Reject operand widths the nibble slicing cannot handle.
    generate
        if ((WIDTH % c_NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("serial_nibble_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic [c_IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic                 r_out_valid;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [WIDTH-1:0]      w_b_eff;
    logic                  w_cin_eff;
    logic [c_NIBBLE_W-1:0] w_x;
    logic [c_NIBBLE_W-1:0] w_y;
    logic [c_NIBBLE_W-1:0] w_s;
    logic                  w_co;

    // Ready depends on state alone so it never combinationally follows in_valid.
    assign w_in_ready = (r_state == IDLE);
    assign w_accept   = bus.in_valid && w_in_ready;

`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
    // Subtraction is folded into the latched operands: store ~b and force the
    // initial carry to 1, so the CALC datapath is identical for both modes.
    assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_eff = bus.sub ? 1'b1   : bus.cin;
`else
    assign w_b_eff   = bus.b;
    assign w_cin_eff = bus.cin;
`endif

    // Select the nibble pair addressed by the running index.
    assign w_x = r_a[r_idx*c_NIBBLE_W +: c_NIBBLE_W];
    assign w_y = r_b[r_idx*c_NIBBLE_W +: c_NIBBLE_W];

    nibble_adder u_nibble_adder (
        .x  (w_x),
        .y  (w_y),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // Controller and datapath: latch on accept, ripple one nibble per cycle,
    // then hold the result until the consumer handshakes it away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.a;
                        r_b     <= w_b_eff;
                        r_carry <= w_cin_eff;
                        r_idx   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_sum[r_idx*c_NIBBLE_W +: c_NIBBLE_W] <= w_s;
                    r_carry <= w_co;
                    if (r_idx == c_LAST) begin
                        r_cout      <= w_co;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + c_ONE;
                    end
                end
                DONE: begin
                    // No same-cycle accept here: IDLE is only reached next cycle.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

endmodule : serial_nibble_adder
`default_nettype wire

// File: tb/tb_serial_nibble_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_nibble_adder
//  Description : Self-checking bench for serial_nibble_adder. A transaction
//                level model predicts handshake and result every cycle;
//                directed cases pin literal results, latency and backpressure.
//                Honours SERIAL_NIBBLE_ADDER_SUB_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_nibble_adder;
    import serial_nibble_adder_pkg::*;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sub_v = 1'b0;

    always #5 clk = ~clk;

    serial_nibble_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_nibble_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
    always_comb bus.sub = sub_v;
`endif

    int checks = 0;
    int errors = 0;

    // Transaction model: busy from accept until released, cnt = edges since accept.
    logic           m_busy  = 1'b0;
    int             m_cnt   = 0;
    logic [WIDTH:0] m_exp   = '0;
    logic           m_clear = 1'b1;
    logic           started = 1'b0;

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c, input logic s);
        if (s)
            return {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        else
            return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on every rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            m_clear <= 1'b1;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy  <= 1'b1;
                m_cnt   <= 0;
                m_exp   <= ref_sum(bus.a, bus.b, bus.cin, sub_v);
                m_clear <= 1'b0;
            end
        end else if (m_cnt < NIB) begin
            m_cnt <= m_cnt + 1;
        end else if (bus.out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", {31'b0, bus.in_ready}, {31'b0, !m_busy});
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, (m_busy && m_cnt == NIB)});
            if (m_busy && m_cnt == NIB) begin
                chk("model_sum", {16'b0, bus.sum}, {16'b0, m_exp[WIDTH-1:0]});
                chk("model_cout", {31'b0, bus.cout}, {31'b0, m_exp[WIDTH]});
            end
            if (m_clear) begin
                chk("cleared_sum", {16'b0, bus.sum}, 32'h0);
                chk("cleared_cout", {31'b0, bus.cout}, 32'h0);
            end
        end
    end

    // One transaction: offer at a negedge, expect out_valid in cycle 5, hold, release.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                          input logic tc, input logic ts,
                          input logic [WIDTH-1:0] es, input logic ec,
                          input string name, input int hold);
        int lat;
        bus.a        = ta;
        bus.b        = tbv;
        bus.cin      = tc;
        sub_v        = ts;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            bus.cin      = 1'($urandom);
            bus.in_valid = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(NIB + 1));
        chk({name, "_sum"}, {16'b0, bus.sum}, {16'b0, es});
        chk({name, "_cout"}, {31'b0, bus.cout}, {31'b0, ec});
        for (int k = 0; k < hold; k++) begin
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk({name, "_hold_sum"}, {16'b0, bus.sum}, {16'b0, es});
            chk({name, "_hold_in_ready"}, {31'b0, bus.in_ready}, 32'h0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "_release_in_ready"}, {31'b0, bus.in_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH:0]   e;
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;

        repeat (3) @(negedge clk);
        started = 1'b1;
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'h1);
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("reset_sum", {16'b0, bus.sum}, 32'h0);
        rst_n = 1'b1;

        run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, "basic", 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "ripple", 0);
        run_op(16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, "carry_in", 0);
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h68AC, 1'b0, "backpressure", 10);

        // Abort in the middle of CALC (index 2), then a clean add.
        bus.a        = 16'hABCD;
        bus.b        = 16'h1234;
        bus.cin      = 1'b0;
        sub_v        = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready", {31'b0, bus.in_ready}, 32'h1);
        chk("abort_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("abort_sum", {16'b0, bus.sum}, 32'h0);
        chk("abort_cout", {31'b0, bus.cout}, 32'h0);
        run_op(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, "after_abort", 0);

`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, "sub_borrow", 0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, "sub_noborrow", 0);
`endif

        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            e = ref_sum(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, e[WIDTH-1:0], e[WIDTH], "random",
                   int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_nibble_adder
`default_nettype wire
